// File: rtl/exp_pkg.sv
// Shared constants and types for the expand-layer bias ping-pong loader.
package exp_pkg;
  localparam int BANK_CNT    = 2;
  localparam int DEF_DATA_W  = 64;
  localparam int DEF_ADDR_W  = 6;
  localparam int DEF_FIFO_AW = 6;

  typedef logic [0:0] bank_t;
endpackage

// File: rtl/exp_bash_dpram.sv
// Simple dual-port RAM holding both bias banks; registered read with one cycle of latency.
module exp_bash_dpram #(
  parameter int DATA_W = 64,
  parameter int AW     = 7
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Output register is reset so the read port shows zero straight out of reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  rdata_o <= '0;
    else if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/synch_fifo.sv
// Single-clock FIFO, show-ahead off: rd_data_o is valid the cycle after an accepted rd_en_i.
module synch_fifo #(
  parameter int DW = 64,
  parameter int AW = 6
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          clr_i,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  output logic [DW-1:0] rd_data_o,
  output logic          empty_o,
  output logic [AW:0]   data_count_o
);
  logic [DW-1:0] mem_q [2**AW];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          full, wr_ok, rd_ok;

  // Occupancy never exceeds the depth, so the top count bit alone means full.
  assign full         = count_q[AW];
  assign empty_o      = (count_q == '0);
  assign wr_ok        = wr_en_i & ~full & ~clr_i;
  assign rd_ok        = rd_en_i & ~empty_o & ~clr_i;
  assign data_count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      rd_data_o <= '0;
    end else if (clr_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + AW'(1);
      if (rd_ok) begin
        rd_data_o <= mem_q[rptr_q];
        rptr_q    <= rptr_q + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/exp_bash_pp_controller.sv
// Ping-pong bias loader: drains the bias FIFO into the write bank while the active bank
// streams cyclically to the expand datapath.
module exp_bash_pp_controller
  import exp_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int FIFO_AW = DEF_FIFO_AW
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               fifo_clr_i,
  input  logic [DATA_W-1:0]  fifo_wr_data_i,
  input  logic               fifo_wr_en_i,
  output logic [FIFO_AW:0]   fifo_data_count_o,
  input  logic               load_start_i,
  input  logic [ADDR_W-1:0]  load_len_i,
  output logic               load_busy_o,
  output logic               load_done_o,
  input  logic               swap_i,
  output logic               bank_ready_o,
  output logic               active_bank_o,
  input  logic               rd_req_i,
  output logic [DATA_W-1:0]  rd_data_o,
  output logic               rd_valid_o,
  output logic               rd_wrap_o,
  output logic               err_o
);
  bank_t                active_q, wb;
  logic [BANK_CNT-1:0]  full_q;
  logic [ADDR_W-1:0]    len_q [BANK_CNT];
  logic [ADDR_W-1:0]    issued_q, wr_cnt_q, rd_addr_q;
  logic                 busy_q, we_q, we_last_q, done_q, ready_q, err_q;
  logic                 rd_valid_q, rd_wrap_q;
  logic                 fifo_empty, fifo_rd, issue_last;
  logic                 load_ok, swap_ok, rd_ok, rd_last;
  logic [DATA_W-1:0]    fifo_rdata;

  assign wb         = ~active_q;
  assign fifo_rd    = busy_q & ~fifo_empty;
  assign issue_last = fifo_rd & (issued_q == len_q[wb]);
  // The final RAM write (we_q) still belongs to the running load.
  assign load_ok    = ~busy_q & ~we_q & ~full_q[wb];
  assign swap_ok    = full_q[wb] & ~busy_q & ~we_q;
  // Read handshake: rd_req_i is taken only while bank_ready_o is high; each taken
  // request yields exactly one rd_valid_o pulse with its data on the following cycle.
  assign rd_ok      = rd_req_i & ready_q;
  assign rd_last    = (rd_addr_q == len_q[active_q]);

  synch_fifo #(.DW(DATA_W), .AW(FIFO_AW)) u_fifo (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .clr_i        (fifo_clr_i),
    .wr_en_i      (fifo_wr_en_i),
    .wr_data_i    (fifo_wr_data_i),
    .rd_en_i      (fifo_rd),
    .rd_data_o    (fifo_rdata),
    .empty_o      (fifo_empty),
    .data_count_o (fifo_data_count_o)
  );

  exp_bash_dpram #(.DATA_W(DATA_W), .AW(ADDR_W+1)) u_ram (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .we_i    (we_q),
    .waddr_i ({wb, wr_cnt_q}),
    .wdata_i (fifo_rdata),
    .re_i    (rd_ok),
    .raddr_i ({active_q, rd_addr_q}),
    .rdata_o (rd_data_o)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      active_q   <= '0;
      full_q     <= '0;
      for (int b = 0; b < BANK_CNT; b++) len_q[b] <= '0;
      issued_q   <= '0;
      wr_cnt_q   <= '0;
      rd_addr_q  <= '0;
      busy_q     <= 1'b0;
      we_q       <= 1'b0;
      we_last_q  <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_wrap_q  <= 1'b0;
    end else begin
      err_q      <= (load_start_i & ~load_ok) | (swap_i & ~swap_ok) | (rd_req_i & ~ready_q);
      done_q     <= 1'b0;
      we_q       <= fifo_rd;
      we_last_q  <= issue_last;
      rd_valid_q <= rd_ok;
      rd_wrap_q  <= rd_ok & rd_last;

      if (load_start_i && load_ok) begin
        len_q[wb] <= load_len_i;
        issued_q  <= '0;
        wr_cnt_q  <= '0;
        busy_q    <= 1'b1;
      end else if (fifo_rd) begin
        if (issue_last) busy_q   <= 1'b0;
        else            issued_q <= issued_q + ADDR_W'(1);
      end

      if (we_q) begin
        wr_cnt_q <= wr_cnt_q + ADDR_W'(1);
        if (we_last_q) begin
          full_q[wb] <= 1'b1;
          done_q     <= 1'b1;
        end
      end

      // A swap restarts the read pointer even if a read of the old bank is taken this cycle.
      if (swap_i && swap_ok) begin
        active_q         <= ~active_q;
        full_q[active_q] <= 1'b0;
        ready_q          <= 1'b1;
        rd_addr_q        <= '0;
      end else if (rd_ok) begin
        rd_addr_q <= rd_last ? '0 : rd_addr_q + ADDR_W'(1);
      end
    end
  end

  assign load_busy_o   = busy_q;
  assign load_done_o   = done_q;
  assign bank_ready_o  = ready_q;
  assign active_bank_o = active_q;
  assign rd_valid_o    = rd_valid_q;
  assign rd_wrap_o     = rd_wrap_q;
  assign err_o         = err_q;
endmodule

// File: tb/tb_exp_bash_pp_controller.sv
// Bench for exp_bash_pp_controller: queue-based behavioural model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_exp_bash_pp_controller;
  localparam int DW = 64, AW = 6, FAW = 6;
  localparam int DEPTH = 1 << AW, FDEPTH = 1 << FAW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          fifo_clr = 0, fifo_wr_en = 0, load_start = 0, swap = 0, rd_req = 0;
  logic [DW-1:0] fifo_wr_data = '0;
  logic [AW-1:0] load_len = '0;
  logic [FAW:0]  fifo_data_count;
  logic          load_busy, load_done, bank_ready, active_bank, rd_valid, rd_wrap, err;
  logic [DW-1:0] rd_data;

  exp_bash_pp_controller #(.DATA_W(DW), .ADDR_W(AW), .FIFO_AW(FAW)) dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .fifo_clr_i        (fifo_clr),
    .fifo_wr_data_i    (fifo_wr_data),
    .fifo_wr_en_i      (fifo_wr_en),
    .fifo_data_count_o (fifo_data_count),
    .load_start_i      (load_start),
    .load_len_i        (load_len),
    .load_busy_o       (load_busy),
    .load_done_o       (load_done),
    .swap_i            (swap),
    .bank_ready_o      (bank_ready),
    .active_bank_o     (active_bank),
    .rd_req_i          (rd_req),
    .rd_data_o         (rd_data),
    .rd_valid_o        (rd_valid),
    .rd_wrap_o         (rd_wrap),
    .err_o             (err)
  );

  int n_cmp = 0, n_bad = 0, done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_fq [$];
  logic [DW-1:0] m_mem [2][DEPTH];
  logic [DW:0]   exp_q [$];
  int  m_len [2];
  bit  m_full [2];
  bit  m_busy, m_pend, m_ready;
  int  m_issued, m_active, m_ptr;
  bit  e_busy, e_done, e_ready, e_err, e_valid;
  int  e_active, e_count;
  int  t_wb, t_act, t_ptr, t_sz;
  bit  t_busy, t_fullwb, t_ready, t_pend, t_swapped;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fq.delete(); exp_q.delete();
      m_len[0] = 0; m_len[1] = 0; m_full[0] = 0; m_full[1] = 0;
      m_busy = 0; m_pend = 0; m_ready = 0; m_issued = 0; m_active = 0; m_ptr = 0;
      e_busy = 0; e_done = 0; e_ready = 0; e_err = 0; e_valid = 0; e_active = 0; e_count = 0;
    end else begin
      t_wb = 1 - m_active; t_act = m_active; t_ptr = m_ptr; t_sz = m_fq.size();
      t_busy = m_busy; t_fullwb = m_full[t_wb]; t_ready = m_ready; t_pend = m_pend;
      t_swapped = 0;
      e_err = 0; e_done = 0; e_valid = 0;
      // the bank is marked full one cycle after the word that completes it leaves the FIFO
      if (t_pend) begin m_full[t_wb] = 1; e_done = 1; m_pend = 0; end
      if (t_busy && t_sz > 0) begin
        m_mem[t_wb][m_issued] = m_fq.pop_front();
        if (m_issued == m_len[t_wb]) begin m_busy = 0; m_pend = 1; end
        else m_issued++;
      end
      if (fifo_clr) m_fq.delete();
      else if (fifo_wr_en && t_sz < FDEPTH) m_fq.push_back(fifo_wr_data);
      if (load_start) begin
        if (!t_busy && !t_pend && !t_fullwb) begin
          m_len[t_wb] = int'(load_len); m_busy = 1; m_issued = 0;
        end else e_err = 1;
      end
      if (swap) begin
        if (t_fullwb && !t_busy && !t_pend) begin
          m_full[t_act] = 0; m_active = 1 - t_act; m_ready = 1; m_ptr = 0; t_swapped = 1;
        end else e_err = 1;
      end
      if (rd_req) begin
        if (t_ready) begin
          exp_q.push_back({1'(t_ptr == m_len[t_act]), m_mem[t_act][t_ptr]});
          e_valid = 1;
          if (!t_swapped) m_ptr = (t_ptr == m_len[t_act]) ? 0 : t_ptr + 1;
        end else e_err = 1;
      end
      e_busy = m_busy; e_ready = m_ready; e_active = m_active; e_count = m_fq.size();
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [DW:0] cap_q [$];
  logic [DW:0] exp_item;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("load_busy", load_busy, e_busy);
      chk("load_done", load_done, e_done);
      chk("bank_ready", bank_ready, e_ready);
      chk("active_bank", active_bank, e_active);
      chk("err", err, e_err);
      chk("fifo_count", fifo_data_count, e_count);
      chk("rd_valid", rd_valid, e_valid);
      if (e_valid) begin
        if (exp_q.size() == 0) chk("exp_q_empty", 1, 0);
        else begin
          exp_item = exp_q.pop_front();
          chk("rd_data", rd_data, exp_item[DW-1:0]);
          chk("rd_wrap", rd_wrap, exp_item[DW]);
        end
      end
      if (rd_valid) cap_q.push_back({rd_wrap, rd_data});
      if (load_done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
    fifo_wr_en = 0; fifo_clr = 0; load_start = 0; swap = 0; rd_req = 0;
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_wr_data = w; fifo_wr_en = 1; tick();
  endtask

  task automatic wait_done(input int budget, input bit rd);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      rd_req = rd; tick(); seen = load_done;
    end
    chk("load_done_seen", seen, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, load_busy, 0);   chk({tag, "_done"}, load_done, 0);
    chk({tag, "_ready"}, bank_ready, 0); chk({tag, "_active"}, active_bank, 0);
    chk({tag, "_valid"}, rd_valid, 0);   chk({tag, "_wrap"}, rd_wrap, 0);
    chk({tag, "_err"}, err, 0);          chk({tag, "_count"}, fifo_data_count, 0);
    chk({tag, "_data"}, rd_data, 0);
  endtask

  logic [DW-1:0] lit_t1 [10] = '{64'hA000_0000_0000_0000, 64'hA000_0000_0000_0001,
    64'hA000_0000_0000_0002, 64'hA000_0000_0000_0003, 64'hA000_0000_0000_0000,
    64'hA000_0000_0000_0001, 64'hA000_0000_0000_0002, 64'hA000_0000_0000_0003,
    64'hA000_0000_0000_0000, 64'hA000_0000_0000_0001};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1; tick();

    // read before any swap is rejected
    rd_req = 1; tick();
    chk("early_rd_err", err, 1);
    chk("early_rd_valid", rd_valid, 0);

    // synchronous FIFO clear
    for (int i = 0; i < 3; i++) push(64'hDEAD_0000_0000_0000 + 64'(i));
    chk("fifo_cnt3", fifo_data_count, 3);
    fifo_clr = 1; tick();
    chk("fifo_clr", fifo_data_count, 0);

    // scenario 1: 4 words into bank 1, swap, 10 cyclic reads
    for (int i = 0; i < 4; i++) push(64'hA000_0000_0000_0000 + 64'(i));
    load_len = 3; load_start = 1; tick();
    chk("t1_busy", load_busy, 1);
    wait_done(20, 0);
    tick();
    chk("t1_done_cnt", done_cnt, 1);
    swap = 1; tick();
    chk("t1_ready", bank_ready, 1);
    chk("t1_active", active_bank, 1);
    cap_q.delete();
    for (int i = 0; i < 10; i++) begin rd_req = 1; tick(); end
    tick();
    chk("t1_nreads", cap_q.size(), 10);
    for (int i = 0; i < 10 && i < cap_q.size(); i++) begin
      chk("t1_data", cap_q[i][DW-1:0], lit_t1[i]);
      chk("t1_wrap", cap_q[i][DW], (i == 3 || i == 7) ? 1 : 0);
    end

    // scenario 2: slow FIFO, len=7 into bank 0
    load_len = 7; load_start = 1; tick();
    for (int i = 0; i < 8; i++) begin
      push(64'hB000_0000_0000_0000 + 64'(i));
      chk("t2_busy", load_busy, 1);
      if (i < 7) repeat (4) tick();
    end
    wait_done(10, 0);
    tick();
    chk("t2_done_cnt", done_cnt, 2);

    // scenario 3: stream bank 0 while bank 1 loads 64 words, then swap under traffic
    swap = 1; tick();
    chk("t3_active0", active_bank, 0);
    load_len = 63; load_start = 1; rd_req = 1; tick();
    for (int i = 0; i < 64; i++) begin
      rd_req = 1; push(64'hC000_0000_0000_0000 + 64'(i));
    end
    wait_done(10, 1);
    swap = 1; rd_req = 1; tick();
    chk("t3_active1", active_bank, 1);
    for (int i = 0; i < 6; i++) begin rd_req = 1; tick(); end
    // bank 0 is free again, so a new load is taken
    load_len = 1; load_start = 1; tick();
    chk("t3_reload_busy", load_busy, 1);
    chk("t3_reload_err", err, 0);

    // scenario 4: rejected commands
    load_start = 1; tick();
    chk("t4_load_busy_err", err, 1);
    swap = 1; tick();
    chk("t4_swap_err", err, 1);
    chk("t4_active", active_bank, 1);
    push(64'hD000_0000_0000_0000); push(64'hD000_0000_0000_0001);
    wait_done(10, 0);

    // scenario 5: load and swap together with the write bank full
    load_start = 1; swap = 1; tick();
    chk("t5_err", err, 1);
    chk("t5_active", active_bank, 0);
    chk("t5_busy", load_busy, 0);
    for (int i = 0; i < 3; i++) begin rd_req = 1; tick(); end

    // scenario 6: asynchronous reset mid-load, then a fresh 2-word load
    for (int i = 0; i < 8; i++) push(64'hE000_0000_0000_0000 + 64'(i));
    load_len = 7; load_start = 1; tick();
    repeat (4) tick();
    #2 rst_n = 0;
    #1 chk_all_zero("async_rst");
    tick();
    rst_n = 1; tick();
    push(64'hF000_0000_0000_0000); push(64'hF000_0000_0000_0001);
    load_len = 1; load_start = 1; tick();
    wait_done(10, 0);
    swap = 1; tick();
    cap_q.delete();
    for (int i = 0; i < 3; i++) begin rd_req = 1; tick(); end
    tick();
    chk("t6_nreads", cap_q.size(), 3);
    if (cap_q.size() == 3) begin
      chk("t6_w0", cap_q[0], {1'b0, 64'hF000_0000_0000_0000});
      chk("t6_w1", cap_q[1], {1'b1, 64'hF000_0000_0000_0001});
      chk("t6_w2", cap_q[2], {1'b0, 64'hF000_0000_0000_0000});
    end
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
